// File: rtl/hann_frame_sequencer.sv
`timescale 1ns/1ps
// hann_frame_sequencer
// Cuts the continuous sample stream into N = 2^FFT_LEN_LOG2 sample frames
// for the Hann window multiplier. A frame is admitted only when downstream
// is ready at frame start, and once started it always runs to completion.
// A programmable holdoff discards samples between frames to set the update rate.
//
// Build option: define HANN_SEQ_DROP_COUNT_EN to count missed frame slots
// in o_dropped_count. Without it the miss logic is absent and
// o_dropped_count is held at zero.

module hann_frame_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int FFT_LEN_LOG2 = 10,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [CNT_WIDTH-1:0]    i_holdoff,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_valid,
    input  logic                    i_win_ready,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_valid,
    output logic [FFT_LEN_LOG2-1:0] o_index,
    output logic                    o_first,
    output logic                    o_last,
    output logic                    o_busy,
    output logic [CNT_WIDTH-1:0]    o_frame_count,
    output logic [CNT_WIDTH-1:0]    o_dropped_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        CAPTURE    = 2'd2,
        HOLDOFF    = 2'd3
    } state_t;

    localparam logic [FFT_LEN_LOG2-1:0] IDX_MAX = {FFT_LEN_LOG2{1'b1}};
    localparam logic [FFT_LEN_LOG2-1:0] IDX_ONE = FFT_LEN_LOG2'(1);
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]    CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                  state;
    state_t                  state_next;
    logic [FFT_LEN_LOG2-1:0] sample_cnt;
    logic [CNT_WIDTH-1:0]    holdoff_cnt;

    logic emit;
    logic start;
    logic frame_done;
    logic hold_load;
    logic hold_step;

    // State register; reset returns the sequencer to IDLE and abandons any partial frame
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus per-sample control strobes for the datapath
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        start      = 1'b0;
        frame_done = 1'b0;
        hold_load  = 1'b0;
        hold_step  = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable) begin
                    state_next = WAIT_START;
                end
            end
            WAIT_START: begin
                if (!i_enable) begin
                    state_next = IDLE;
                end else if (i_valid && i_win_ready) begin
                    emit       = 1'b1;
                    start      = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (i_valid) begin
                    emit = 1'b1;
                    if (sample_cnt == IDX_MAX) begin
                        frame_done = 1'b1;
                        if (!i_enable) begin
                            state_next = IDLE;
                        end else if (i_holdoff != '0) begin
                            hold_load  = 1'b1;
                            state_next = HOLDOFF;
                        end else begin
                            state_next = WAIT_START;
                        end
                    end
                end
            end
            HOLDOFF: begin
                if (!i_enable) begin
                    state_next = IDLE;
                end else if (i_valid) begin
                    hold_step = 1'b1;
                    if (holdoff_cnt <= CNT_ONE) begin
                        state_next = WAIT_START;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output register: samples pass through untouched, markers are single-cycle pulses
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data  <= '0;
            o_index <= '0;
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_valid <= emit;
            o_first <= start;
            o_last  <= frame_done;
            o_busy  <= (state != IDLE);
            if (emit) begin
                o_data  <= i_data;
                o_index <= start ? '0 : sample_cnt;
            end
        end
    end

    // Sample index within the frame; wraps from N-1 back to 0 on the last sample
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sample_cnt <= '0;
        end else if (start) begin
            sample_cnt <= IDX_ONE;
        end else if (emit) begin
            sample_cnt <= sample_cnt + IDX_ONE;
        end
    end

    // Holdoff down-counter, loaded from i_holdoff when the frame completes
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            holdoff_cnt <= '0;
        end else if (hold_load) begin
            holdoff_cnt <= i_holdoff;
        end else if (hold_step) begin
            holdoff_cnt <= holdoff_cnt - CNT_ONE;
        end else if (state == HOLDOFF && state_next == IDLE) begin
            holdoff_cnt <= '0;
        end
    end

    // Completed-frame counter, free-running with natural wrap
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_frame_count <= '0;
        end else if (frame_done) begin
            o_frame_count <= o_frame_count + CNT_ONE;
        end
    end

`ifdef HANN_SEQ_DROP_COUNT_EN
    logic                    miss;
    logic [FFT_LEN_LOG2-1:0] miss_cnt;

    assign miss = (state == WAIT_START) && i_enable && i_valid && !i_win_ready;

    // Every N consecutive not-ready samples is one lost frame slot; the count saturates
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            miss_cnt        <= '0;
            o_dropped_count <= '0;
        end else if (state != WAIT_START || state_next != WAIT_START) begin
            miss_cnt <= '0;
        end else if (miss) begin
            if (miss_cnt == IDX_MAX) begin
                miss_cnt <= '0;
                if (o_dropped_count != CNT_MAX) begin
                    o_dropped_count <= o_dropped_count + CNT_ONE;
                end
            end else begin
                miss_cnt <= miss_cnt + IDX_ONE;
            end
        end
    end
`else
    assign o_dropped_count = '0;
`endif

endmodule

// File: tb/tb_hann_frame_sequencer.sv
`timescale 1ns/1ps
// Directed testbench for hann_frame_sequencer at N = 8.
// Expected output beats are queued as samples are driven and
// compared in order as the DUT presents them.

module tb_hann_frame_sequencer;

    localparam int DW = 32;
    localparam int LG = 3;
    localparam int CW = 16;
    localparam int N  = 8;

`ifdef HANN_SEQ_DROP_COUNT_EN
    localparam int DROPS_AFTER_20 = 2;
`else
    localparam int DROPS_AFTER_20 = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [CW-1:0] holdoff;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          win_ready;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [LG-1:0] index_out;
    logic          first_out;
    logic          last_out;
    logic          busy;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] dropped_count;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [LG-1:0] index;
        logic          first;
        logic          last;
    } beat_t;

    beat_t expq[$];
    beat_t mon_got;
    beat_t mon_want;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    hann_frame_sequencer #(
        .DATA_WIDTH  (DW),
        .FFT_LEN_LOG2(LG),
        .CNT_WIDTH   (CW)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_enable       (enable),
        .i_holdoff      (holdoff),
        .i_data         (data_in),
        .i_valid        (valid_in),
        .i_win_ready    (win_ready),
        .o_data         (data_out),
        .o_valid        (valid_out),
        .o_index        (index_out),
        .o_first        (first_out),
        .o_last         (last_out),
        .o_busy         (busy),
        .o_frame_count  (frame_count),
        .o_dropped_count(dropped_count)
    );

    // Scoreboard monitor: every presented beat must match the oldest expected one
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            checks++;
            assert (expq.size() != 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_beat: observed data %0d index %0d with no beat expected",
                       data_out, index_out);
            end
            if (expq.size() != 0) begin
                mon_got  = {data_out, index_out, first_out, last_out};
                mon_want = expq.pop_front();
                assert (mon_got === mon_want) else begin
                    errors++;
                    $error("[TB] FAIL beat: observed data %0d idx %0d first %0b last %0b, expected data %0d idx %0d first %0b last %0b",
                           mon_got.data, mon_got.index, mon_got.first, mon_got.last,
                           mon_want.data, mon_want.index, mon_want.first, mon_want.last);
                end
            end
        end
    end

    // Global time bound so a stuck run still ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one valid sample; queue its expected beat if it should be emitted
    task automatic apply_stimulus(input int d, input bit expect_out, input int idx);
        data_in  = DW'(d);
        valid_in = 1'b1;
        if (expect_out) begin
            expq.push_back(beat_t'({DW'(d), LG'(idx), (idx == 0), (idx == N - 1)}));
        end
        tick();
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) tick();
    endtask

    // Wait (bounded) for all queued beats to appear
    task automatic drain(input string tag);
        int budget;
        budget   = 0;
        valid_in = 1'b0;
        while (expq.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        check_output(tag, 64'(expq.size()), 64'd0);
        expq.delete();
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        holdoff   = '0;
        data_in   = '0;
        valid_in  = 1'b0;
        win_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check_output("reset_valid", 64'(valid_out), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_data", 64'(data_out), 64'd0);
        check_output("reset_index", 64'(index_out), 64'd0);
        check_output("reset_first_last", 64'({first_out, last_out}), 64'd0);
        check_output("reset_frames", 64'(frame_count), 64'd0);
        check_output("reset_dropped", 64'(dropped_count), 64'd0);
        rst = 1'b0;
        idle(2);

        // Inputs are ignored while disabled
        apply_stimulus(900, 1'b0, 0);
        apply_stimulus(901, 1'b0, 0);
        idle(2);
        check_output("idle_busy", 64'(busy), 64'd0);

        // Basic frames: two back-to-back frames with no gap
        enable = 1'b1;
        idle(2);
        check_output("enable_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 16; i++) apply_stimulus(1 + i, 1'b1, i % N);
        drain("basic_drain");
        check_output("basic_frames", 64'(frame_count), 64'd2);

        // Holdoff of 4; the latched value survives i_holdoff changing mid-holdoff
        holdoff = CW'(4);
        for (int i = 0; i < 8; i++) apply_stimulus(101 + i, 1'b1, i);
        apply_stimulus(109, 1'b0, 0);
        holdoff = '0;
        check_output("holdoff_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) apply_stimulus(110 + i, 1'b0, 0);
        for (int i = 0; i < 8; i++) apply_stimulus(113 + i, 1'b1, i);
        drain("holdoff_drain");
        check_output("holdoff_frames", 64'(frame_count), 64'd4);

        // Not ready for 20 samples, then a frame starting on the 21st
        win_ready = 1'b0;
        for (int i = 0; i < 20; i++) apply_stimulus(201 + i, 1'b0, 0);
        check_output("notready_dropped", 64'(dropped_count), 64'(DROPS_AFTER_20));
        win_ready = 1'b1;
        for (int i = 0; i < 8; i++) apply_stimulus(221 + i, 1'b1, i);
        drain("notready_drain");
        check_output("notready_frames", 64'(frame_count), 64'd5);

        // Leftover misses are cleared when a frame starts
        win_ready = 1'b0;
        for (int i = 0; i < 7; i++) apply_stimulus(301 + i, 1'b0, 0);
        win_ready = 1'b1;
        for (int i = 0; i < 8; i++) apply_stimulus(308 + i, 1'b1, i);
        drain("missclear_drain");
        check_output("missclear_dropped", 64'(dropped_count), 64'(DROPS_AFTER_20));

        // Enable drop at index 3: the frame completes, then IDLE
        for (int i = 0; i < 4; i++) apply_stimulus(401 + i, 1'b1, i);
        enable = 1'b0;
        win_ready = 1'b0;
        for (int i = 4; i < 8; i++) apply_stimulus(401 + i, 1'b1, i);
        check_output("endrop_last", 64'(last_out), 64'd1);
        check_output("endrop_busy_at_last", 64'(busy), 64'd1);
        apply_stimulus(409, 1'b0, 0);
        check_output("endrop_busy_after", 64'(busy), 64'd0);
        win_ready = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus(410 + i, 1'b0, 0);
        drain("endrop_drain");
        check_output("endrop_frames", 64'(frame_count), 64'd7);

        // Reset asserted while index 5 is on the output
        enable = 1'b1;
        idle(2);
        for (int i = 0; i < 5; i++) apply_stimulus(501 + i, 1'b1, i);
        apply_stimulus(506, 1'b0, 0);
        check_output("prereset_index", 64'(index_out), 64'd5);
        rst = 1'b1;
        #1;
        check_output("midreset_valid", 64'(valid_out), 64'd0);
        check_output("midreset_data", 64'(data_out), 64'd0);
        check_output("midreset_index", 64'(index_out), 64'd0);
        check_output("midreset_last", 64'(last_out), 64'd0);
        check_output("midreset_busy", 64'(busy), 64'd0);
        check_output("midreset_frames", 64'(frame_count), 64'd0);
        expq.delete();
        idle(2);
        rst = 1'b0;
        idle(2);
        check_output("postreset_frames", 64'(frame_count), 64'd0);

        // Valid gaps: a fresh frame with idle cycles between samples
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(601 + i, 1'b1, i);
            idle(1);
            if (i == 6) check_output("gap_frames_before", 64'(frame_count), 64'd0);
        end
        drain("gap_drain");
        check_output("gap_frames_after", 64'(frame_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
